// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 types, constants and divider FSM states for the FPU
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } fp32_t;

  localparam int         FP_BIAS    = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'hff;
  localparam int         FP_MANT_W  = 23;
  localparam int         FDIV_QBITS = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fdiv_state_e;

endpackage

// File: rtl/fdiv_step.sv
// rtl/fdiv_step.sv - one combinational restoring-division step producing one quotient bit
module fdiv_step (
  input  logic [24:0] r_in,
  input  logic [25:0] q_in,
  input  logic [23:0] my,
  output logic [24:0] r_out,
  output logic [25:0] q_out
);

  logic [25:0] w_r2;
  logic [25:0] w_dsr;
  logic [25:0] w_diff;
  logic [25:0] w_sel;
  logic        w_ge;
  logic        w_unused_bits;

  // Divisor is compared at 2*my so the first bit produced is the integer digit
  // of mx/my; this keeps the remainder below 2*my and fits in 25 bits.
  assign w_r2   = {r_in, 1'b0};
  assign w_dsr  = {1'b0, my, 1'b0};
  assign w_ge   = (w_r2 >= w_dsr);
  assign w_diff = w_r2 - w_dsr;
  assign w_sel  = w_ge ? w_diff : w_r2;

  assign r_out = w_sel[24:0];
  assign q_out = {q_in[24:0], w_ge};

  assign w_unused_bits = ^{w_sel[25], q_in[25]};

endmodule

// File: rtl/fdiv_iter.sv
// rtl/fdiv_iter.sv - iterative FP32 divider, restoring radix-2, ITER_PER_CYCLE bits per clock
// Optional round-to-nearest-even selected by defining FDIV_ROUND_EN (default: truncate).
module fdiv_iter
  import fpu_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  localparam int CNT_INIT = FDIV_QBITS / ITER_PER_CYCLE;

  fdiv_state_e        r_state;
  fdiv_state_e        w_state_nxt;
  logic [4:0]         r_count;
  logic [4:0]         w_count_nxt;
  logic [24:0]        r_rem;
  logic [25:0]        r_q;
  logic [23:0]        r_my;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic               r_special;
  logic [31:0]        r_special_res;
  logic [31:0]        r_res;
  logic               r_out_valid;

  fp32_t              w_x;
  fp32_t              w_y;
  logic [24:0]        w_r [ITER_PER_CYCLE+1];
  logic [25:0]        w_q [ITER_PER_CYCLE+1];
  logic [22:0]        w_mant;
  logic [23:0]        w_mant_rnd;
  logic signed [9:0]  w_e;
  logic [31:0]        w_result;
`ifdef FDIV_ROUND_EN
  logic               w_g;
  logic               w_st;
`endif

  assign w_x = x;
  assign w_y = y;

  assign w_r[0] = r_rem;
  assign w_q[0] = r_q;

  for (genvar gi = 0; gi < ITER_PER_CYCLE; gi++) begin : g_step
    fdiv_step u_step (
      .r_in  (w_r[gi]),
      .q_in  (w_q[gi]),
      .my    (r_my),
      .r_out (w_r[gi+1]),
      .q_out (w_q[gi+1])
    );
  end

  assign w_count_nxt = r_count - 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = DIV;
      DIV:     if (w_count_nxt == 5'd0) w_state_nxt = NORM;
      NORM:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Normalise the 26-bit quotient (leading one at bit 25 or 24), round, range-check.
  always_comb begin
    w_e        = r_exp;
    w_mant     = r_q[23:1];
    if (r_q[25]) begin
      w_mant = r_q[24:2];
    end else begin
      w_e = r_exp - 10'sd1;
    end
`ifdef FDIV_ROUND_EN
    w_g        = r_q[25] ? r_q[1] : r_q[0];
    w_st       = (r_q[25] & r_q[0]) | (|r_rem);
    w_mant_rnd = {1'b0, w_mant} + {23'd0, w_g & (w_st | w_mant[0])};
`else
    w_mant_rnd = {1'b0, w_mant};
`endif
    if (w_mant_rnd[23]) begin
      w_mant_rnd = 24'd0;
      w_e        = w_e + 10'sd1;
    end
    if (r_special) begin
      w_result = r_special_res;
    end else if (w_e >= 10'sd255) begin
      w_result = {r_sign, FP_EXP_MAX, 23'd0};
    end else if (w_e <= 10'sd0) begin
      w_result = 32'h0;
    end else begin
      w_result = {r_sign, w_e[7:0], w_mant_rnd[FP_MANT_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= 5'd0;
      r_rem         <= 25'd0;
      r_q           <= 26'd0;
      r_my          <= 24'd0;
      r_sign        <= 1'b0;
      r_exp         <= 10'sd0;
      r_special     <= 1'b0;
      r_special_res <= 32'h0;
      r_res         <= 32'h0;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_count       <= 5'(CNT_INIT);
            r_rem         <= {2'b01, w_x.m};
            r_q           <= 26'd0;
            r_my          <= {1'b1, w_y.m};
            r_sign        <= w_x.s ^ w_y.s;
            r_exp         <= $signed({2'b00, w_x.e}) - $signed({2'b00, w_y.e}) + 10'(FP_BIAS);
            // Divide-by-zero takes priority over a zero dividend.
            r_special     <= (w_y.e == 8'd0) || (w_x.e == 8'd0);
            r_special_res <= (w_y.e == 8'd0) ? {w_x.s ^ w_y.s, FP_EXP_MAX, 23'd0} : 32'h0;
          end
        end
        DIV: begin
          r_rem   <= w_r[ITER_PER_CYCLE];
          r_q     <= w_q[ITER_PER_CYCLE];
          r_count <= w_count_nxt;
        end
        NORM: begin
          r_res       <= w_result;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;

endmodule

// File: tb/tb_fdiv_iter.sv
// tb/tb_fdiv_iter.sv - randomized self-checking bench for fdiv_iter against an arithmetic reference
module tb_fdiv_iter;

  localparam int N   = 1;
  localparam int LAT = 26 / N + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic        held = 1'b0;
  logic [31:0] held_res = 32'h0;

  fdiv_iter #(.ITER_PER_CYCLE(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: exact integer quotient of the 24-bit significands, then IEEE-style packing.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                e;
    int                mant;
    longint unsigned   num;
    longint unsigned   den;
    longint unsigned   q;
    longint unsigned   rem;
    logic [31:0]       ev;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hff, 23'h0};
    if (a[30:23] == 8'd0) return 32'h0;
    num = {40'd0, 1'b1, a[22:0]};
    num = num << 25;
    den = {40'd0, 1'b1, b[22:0]};
    q   = num / den;
    rem = num % den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 25)) begin
      mant = int'((q >> 2) & 64'h7FFFFF);
`ifdef FDIV_ROUND_EN
      if (q[1] && (q[0] || rem != 0 || mant[0])) mant++;
`endif
    end else begin
      mant = int'((q >> 1) & 64'h7FFFFF);
      e    = e - 1;
`ifdef FDIV_ROUND_EN
      if (q[0] && (rem != 0 || mant[0])) mant++;
`endif
    end
    if (mant == (1 << 23)) begin
      mant = 0;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hff, 23'h0};
    if (e <= 0) return 32'h0;
    ev = e;
    return {s, ev[7:0], 23'(mant)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    int         k;
    k = $urandom_range(0, 9);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hfe;
    else if (k == 2) e = 8'h01;
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Output checker: each new result is matched against the queue, then held stable until taken.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (out_valid) begin
      if (!held) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: got %h expected none", res);
        end else begin
          chk("result", res, exp_q.pop_front());
          chk("latency", 32'(cyc), 32'(acc_q.pop_front() + LAT));
        end
        held     = 1'b1;
        held_res = res;
      end else begin
        chk("res_stable", res, held_res);
      end
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_ready) held = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    x = a;
    y = b;
    while (!in_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(model(a, b));
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
  endtask

  task automatic wait_done(input bit bp);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 400) begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    if (t >= 400) chk("done_timeout", 32'd0, 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] third;
    int          t;
`ifdef FDIV_ROUND_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 32'h0;
    y         = 32'h0;

    chk("model_6_2", model(32'h40C00000, 32'h40000000), 32'h40400000);
    chk("model_1_3", model(32'h3F800000, 32'h40400000), third);
    chk("model_div0", model(32'hC0000000, 32'h00000000), 32'hFF800000);
    chk("model_ovf", model(32'h7F000000, 32'h3E800000), 32'h7F800000);
    chk("model_unf", model(32'h00800000, 32'h40000000), 32'h00000000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'h0);
    @(posedge clk); #1;

    issue(32'h40C00000, 32'h40000000); wait_done(1'b0);
    issue(32'h3F800000, 32'h40400000); wait_done(1'b0);
    issue(32'hC0000000, 32'h00000000); wait_done(1'b0);
    issue(32'h00000000, 32'h40A00000); wait_done(1'b0);
    issue(32'h00000000, 32'h00000000); wait_done(1'b0);
    issue(32'h7F000000, 32'h3E800000); wait_done(1'b0);
    issue(32'h00800000, 32'h40000000); wait_done(1'b0);

    // Backpressure: result held, second request ignored until the divider is idle again.
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      x = 32'h3F800000;
      y = 32'h40400000;
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_res", res, 32'h40400000);
    end
    out_ready = 1'b1;
    issue(32'h3F800000, 32'h40400000);
    wait_done(1'b0);

    // Reset during DIV drops the operation.
    issue(32'h40C00000, 32'h40000000);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_res", res, 32'h0);
    issue(32'h40C00000, 32'h40000000);
    wait_done(1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(rnd_fp(), rnd_fp());
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
